// File: rtl/lsu_pipe.sv
// lsu_pipe: memory-stage load/store unit with lane alignment and a
// request/ack handshake to data memory.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   req_valid/we/funct3 memory instruction from the M stage
//   req_addr/wdata/rd   byte address, right-justified store data, dest
//   stall               hold upstream stages while an access is pending
//   mem_req/we/be       memory request, write strobe, byte enables
//   mem_addr/wdata      aligned address, lane-shifted store data
//   mem_ack/rdata       access complete, aligned read word
//   wb_valid/data/rd    one-cycle load result to write-back
//   err_misaligned      one-cycle pulse, access rejected
//   err_timeout         one-cycle pulse, no ack within TIMEOUT cycles
module lsu_pipe #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              err_misaligned,
  output logic              err_timeout
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LIM =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [OW-1:0]   r_off;
  logic [4:0]      r_rd;

  logic [1:0]      w_size;
  logic [3:0]      w_bytes;
  logic            w_legal;
  logic [OW-1:0]   w_off;
  logic            w_mis;
  logic [NB-1:0]   w_be_base;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_addr;
  logic            w_accept;
  logic            w_hit;

  logic [3:0]      w_rbytes;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;
  logic [XLEN-1:0] w_ext;

  // request decode
  assign w_size  = req_funct3[1:0];
  assign w_bytes = 4'd1 << w_size;
  assign w_legal = (w_size != 2'd3) || (XLEN == 64);
  assign w_off   = req_addr[OW-1:0];
  assign w_mis   = !w_legal ||
                   ((w_off & OW'(w_bytes - 4'd1)) != '0);

  // a full-width access shifts every one out, leaving all lanes set
  assign w_be_base = ~({NB{1'b1}} << w_bytes);
  assign w_be      = w_be_base << w_off;
  assign w_wdata   = req_wdata << {w_off, 3'b000};
  assign w_addr    = req_addr & ~XLEN'(NB - 1);

  assign w_accept = (r_state == S_IDLE) && req_valid && !w_mis;

  // an ack in the last allowed cycle still completes the access
  assign w_hit = (TIMEOUT != 0) && (r_cnt == C_LIM) && !mem_ack;

  assign stall = w_accept ||
                 ((r_state == S_BUSY) && !mem_ack && !w_hit);

  // load extraction
  assign w_rbytes = 4'd1 << r_size;
  assign w_lane   = mem_rdata >> {r_off, 3'b000};
  assign w_mask   = ~({XLEN{1'b1}} << {w_rbytes, 3'b000});

  always_comb begin
    w_sign = 1'b0;
    case (r_size)
      2'd0:    w_sign = w_lane[7];
      2'd1:    w_sign = w_lane[15];
      2'd2:    w_sign = w_lane[31];
      default: w_sign = w_lane[XLEN-1];
    endcase
  end

  assign w_ext = (w_lane & w_mask) |
                 ({XLEN{w_sign && !r_uns}} & ~w_mask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_size         <= '0;
      r_uns          <= 1'b0;
      r_off          <= '0;
      r_rd           <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_rd          <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_mis) begin
              err_misaligned <= 1'b1;
            end else begin
              r_state   <= S_BUSY;
              r_cnt     <= '0;
              r_size    <= w_size;
              r_uns     <= req_funct3[2];
              r_off     <= w_off;
              r_rd      <= req_rd;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= w_be;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              wb_valid <= 1'b1;
              wb_data  <= w_ext;
              wb_rd    <= r_rd;
            end
          end else if (w_hit) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: random and directed checks of lsu_pipe at XLEN=32
// (TIMEOUT=4) and XLEN=64 (TIMEOUT=16) against a byte-level model.
module tb_lsu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_valid, req_we, mem_ack;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  logic        s32_stall, s32_req, s32_we, s32_wbv, s32_mis, s32_to;
  logic [3:0]  s32_be;
  logic [31:0] s32_addr, s32_wdata, s32_wbd;
  logic [4:0]  s32_wbr;

  logic        s64_stall, s64_req, s64_we, s64_wbv, s64_mis, s64_to;
  logic [7:0]  s64_be;
  logic [63:0] s64_addr, s64_wdata, s64_wbd;
  logic [4:0]  s64_wbr;

  lsu_pipe #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
    .stall(s32_stall), .mem_req(s32_req), .mem_we(s32_we),
    .mem_be(s32_be), .mem_addr(s32_addr), .mem_wdata(s32_wdata),
    .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata[31:0]),
    .wb_valid(s32_wbv), .wb_data(s32_wbd), .wb_rd(s32_wbr),
    .err_misaligned(s32_mis), .err_timeout(s32_to)
  );

  lsu_pipe #(.XLEN(64), .TIMEOUT(16)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(s64_stall), .mem_req(s64_req), .mem_we(s64_we),
    .mem_be(s64_be), .mem_addr(s64_addr), .mem_wdata(s64_wdata),
    .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata),
    .wb_valid(s64_wbv), .wb_data(s64_wbd), .wb_rd(s64_wbr),
    .err_misaligned(s64_mis), .err_timeout(s64_to)
  );

  logic        o_stall, o_req, o_we, o_wbv, o_mis, o_to;
  logic [7:0]  o_be;
  logic [63:0] o_addr, o_wdata, o_wbd;
  logic [4:0]  o_wbr;

  always_comb begin
    if (sel) begin
      o_stall = s64_stall; o_req = s64_req; o_we = s64_we;
      o_wbv = s64_wbv; o_mis = s64_mis; o_to = s64_to;
      o_be = s64_be; o_addr = s64_addr; o_wdata = s64_wdata;
      o_wbd = s64_wbd; o_wbr = s64_wbr;
    end else begin
      o_stall = s32_stall; o_req = s32_req; o_we = s32_we;
      o_wbv = s32_wbv; o_mis = s32_mis; o_to = s32_to;
      o_be = {4'b0, s32_be}; o_addr = {32'b0, s32_addr};
      o_wdata = {32'b0, s32_wdata};
      o_wbd = {32'b0, s32_wbd}; o_wbr = s32_wbr;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  bit          p_wb, p_mis, p_to;
  logic [63:0] p_dat;
  logic [4:0]  p_rd;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // load result from byte-level rules: gather bytes, then extend
  function automatic logic [63:0] ld_model(input int xl,
      input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    int nb, b, off;
    logic [63:0] v, one;
    nb = xl / 8;
    b = 1 << f3[1:0];
    off = int'(a[2:0]) % nb;
    one = 64'd1;
    v = '0;
    for (int i = 0; i < b; i++)
      v |= ((d >> (8 * (off + i))) & 64'hff) << (8 * i);
    if (!f3[2] && b < 8 && v[8*b-1])
      v |= ~((one << (8 * b)) - 64'd1);
    if (xl == 32) v &= 64'hffff_ffff;
    return v;
  endfunction

  task automatic chk_pulses();
    chk("wb_valid", 64'(o_wbv), 64'(p_wb));
    if (p_wb) begin
      chk("wb_data", o_wbd, p_dat);
      chk("wb_rd", 64'(o_wbr), 64'(p_rd));
    end
    chk("err_mis", 64'(o_mis), 64'(p_mis));
    chk("err_to", 64'(o_to), 64'(p_to));
    p_wb = 0; p_mis = 0; p_to = 0;
  endtask

  task automatic idle(input bit ack);
    @(posedge clk); #1;
    req_valid = 0;
    mem_ack = ack;
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk_pulses();
    chk("stall_idle", 64'(o_stall), 64'd0);
    chk("req_idle", 64'(o_req), 64'd0);
  endtask

  // k: BUSY cycles before the ack cycle (-1 never acks)
  // rst_at: BUSY cycle in which reset is asserted (-1 none)
  task automatic txn(input bit we, input logic [2:0] f3,
      input logic [63:0] a, input logic [63:0] wd,
      input logic [63:0] rdat, input logic [4:0] rd,
      input int k, input int rst_at,
      input bit hx, input logic [63:0] xv);
    int xl, nb, b, off, to, stc;
    bit mis;
    logic [63:0] eb, ew, em;
    xl = sel ? 64 : 32;
    nb = xl / 8;
    to = sel ? 16 : 4;
    b = 1 << f3[1:0];
    off = int'(a[2:0]) % nb;
    mis = (b == 8 && xl == 32) || (off % b != 0);
    eb = '0; ew = '0; em = '0;
    for (int i = 0; i < b; i++) begin
      eb[off+i] = 1'b1;
      ew |= ((wd >> (8 * i)) & 64'hff) << (8 * (off + i));
      em |= 64'hff << (8 * (off + i));
    end
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    mem_ack = 0;
    @(negedge clk);
    chk_pulses();
    chk("stall_acc", 64'(o_stall), 64'(!mis));
    chk("req_acc", 64'(o_req), 64'd0);
    if (mis) begin
      p_mis = 1;
      return;
    end
    stc = 1;
    for (int c = 0; c < to; c++) begin
      @(posedge clk); #1;
      req_valid = 0;
      mem_ack = (c == k);
      mem_rdata = rdat;
      if (c == rst_at) rst = 0;
      @(negedge clk);
      chk("mem_req", 64'(o_req), 64'd1);
      if (c == 0) begin
        chk("mem_addr", o_addr, a & ~64'(nb - 1));
        chk("mem_be", 64'(o_be), eb);
        chk("mem_we", 64'(o_we), 64'(we));
        if (we) chk("mem_wdata", o_wdata & em, ew);
      end
      stc += int'(o_stall);
      if (c == rst_at) begin
        @(posedge clk); #1;
        rst = 1;
        mem_ack = 0;
        @(negedge clk);
        chk("rst_req", 64'(o_req), 64'd0);
        chk("rst_wbv", 64'(o_wbv), 64'd0);
        chk("rst_to", 64'(o_to), 64'd0);
        return;
      end
      if (c == k) begin
        chk("stall_cnt", 64'(stc), 64'(k + 1));
        p_wb = !we;
        p_dat = hx ? xv : ld_model(xl, f3, a, rdat);
        p_rd = rd;
        return;
      end
      if (c == to - 1) begin
        chk("stall_to", 64'(stc), 64'(to));
        p_to = 1;
        return;
      end
    end
  endtask

  task automatic rand_phase(input int n);
    int to, k, ra, gap;
    bit we;
    logic [2:0] f3;
    logic [63:0] a;
    to = sel ? 16 : 4;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle(1'($urandom_range(0, 1)));
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 64'($urandom_range(0, 255)) + 64'h1000;
      if ($urandom_range(0, 2) != 0)
        a &= ~64'((1 << f3[1:0]) - 1);
      k = $urandom_range(0, (to > 6) ? 5 : to - 1);
      ra = -1;
      case ($urandom_range(0, 9))
        0: k = -1;
        1: if (k >= 1) ra = $urandom_range(0, k - 1);
        default: ;
      endcase
      txn(we, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
          5'($urandom_range(1, 31)), k, ra, 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; rst = 0; req_valid = 0; req_we = 0; mem_ack = 0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    req_rd = '0; mem_rdata = '0;
    p_wb = 0; p_mis = 0; p_to = 0; p_dat = '0; p_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_stall", 64'(o_stall), 64'd0);
      chk("rst_mreq", 64'(o_req), 64'd0);
      chk("rst_mwe", 64'(o_we), 64'd0);
      chk("rst_be", 64'(o_be), 64'd0);
      chk("rst_addr", o_addr, 64'd0);
      chk("rst_wdata", o_wdata, 64'd0);
      chk("rst_wbv", 64'(o_wbv), 64'd0);
      chk("rst_wbd", o_wbd, 64'd0);
      chk("rst_wbr", 64'(o_wbr), 64'd0);
      chk("rst_mis", 64'(o_mis), 64'd0);
      chk("rst_to", 64'(o_to), 64'd0);
    end
    sel = 0;
    rst = 1;

    txn(1, 3'b000, 64'h103, 64'hAB, 64'h0, 5'd0, 2, -1, 0, 0);
    txn(0, 3'b001, 64'h102, 64'h0, 64'h8001_1234, 5'd5, 0, -1,
        1, 64'hFFFF_8001);
    txn(0, 3'b101, 64'h102, 64'h0, 64'h8001_1234, 5'd6, 1, -1,
        1, 64'h0000_8001);
    txn(0, 3'b000, 64'h101, 64'h0, 64'h8001_1234, 5'd7, 0, -1,
        1, 64'h0000_0012);
    txn(0, 3'b010, 64'h101, 64'h0, 64'h0, 5'd8, 0, -1, 0, 0);
    idle(0);
    txn(0, 3'b010, 64'h200, 64'h0, 64'h0, 5'd9, -1, -1, 0, 0);
    idle(0);
    txn(0, 3'b010, 64'h204, 64'h0, 64'h1234, 5'd10, 3, 1, 0, 0);
    txn(0, 3'b010, 64'h208, 64'h0, 64'hCAFE_F00D, 5'd11, 0, -1,
        1, 64'hCAFE_F00D);
    rand_phase(60);
    idle(0);

    sel = 1;
    txn(0, 3'b011, 64'h10, 64'h0, 64'h8000_0001_0000_0002, 5'd1, 1, -1,
        1, 64'h8000_0001_0000_0002);
    txn(0, 3'b110, 64'h14, 64'h0, 64'h8000_0001_0000_0002, 5'd2, 0, -1,
        1, 64'h0000_0000_8000_0001);
    txn(0, 3'b011, 64'h14, 64'h0, 64'h0, 5'd3, 0, -1, 0, 0);
    idle(0);
    rand_phase(60);
    idle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
